// File: rtl/vec_pkg.sv
// Shared constants, step counter type and FSM state encoding for the vector divider.
package vec_pkg;

   localparam int unsigned LANES = 16;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t CNT_END = cnt_t'(WIDTH);

   typedef enum logic [2:0] {IDLE, PREP, DIV, FIX, DONE} state_t;

   localparam logic [WIDTH-1:0] QMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] QMIN = {1'b1, {(WIDTH-1){1'b0}}};

endpackage

// File: rtl/vec_div_lane.sv
// One lane of the signed 2W/W restoring divider: magnitude prep, one quotient bit per
// DIV cycle, sign fix-up and div-by-zero/overflow handling. Status flags under VEC_DIV_STATUS_EN.
module vec_div_lane
   import vec_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  state_t           state_i,
   input  cnt_t             count_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] dvd_lo_i,
   input  logic [WIDTH-1:0] dvd_hi_i,
   input  logic [WIDTH-1:0] dsr_i,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] rem_o
`ifdef VEC_DIV_STATUS_EN
   ,
   output logic             div0_o,
   output logic             ovf_o
`endif
);

   logic [WIDTH-1:0]   lo_q, hi_q, dsr_q, mag_q, prem_q, sh_q, quot_q, rem_q;
   logic               q_neg_q, r_neg_q, ovf_pre_q;
   logic [2*WIDTH-1:0] dvd_abs;
   logic [WIDTH-1:0]   dsr_abs, diff, q_sgn, r_sgn;
   logic [WIDTH:0]     shifted;
   logic               fits, is_div0, is_ovf;

   // sh_q starts as the low magnitude word and is shifted out as quotient bits shift in
   always_comb begin
      dvd_abs = hi_q[WIDTH-1] ? -{hi_q, lo_q} : {hi_q, lo_q};
      dsr_abs = dsr_q[WIDTH-1] ? -dsr_q : dsr_q;
      shifted = {prem_q, sh_q[WIDTH-1]};
      fits    = shifted >= {1'b0, mag_q};
      diff    = shifted[WIDTH-1:0] - mag_q;
      q_sgn   = q_neg_q ? -sh_q : sh_q;
      r_sgn   = r_neg_q ? -prem_q : prem_q;
      is_div0 = (dsr_q == '0);
      is_ovf  = ovf_pre_q || (q_neg_q ? (sh_q > QMIN) : sh_q[WIDTH-1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_q      <= '0;
         hi_q      <= '0;
         dsr_q     <= '0;
         mag_q     <= '0;
         prem_q    <= '0;
         sh_q      <= '0;
         quot_q    <= '0;
         rem_q     <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         ovf_pre_q <= 1'b0;
      end else begin
         if (load_i) begin
            lo_q  <= dvd_lo_i;
            hi_q  <= dvd_hi_i;
            dsr_q <= dsr_i;
         end
         case (state_i)
            PREP: begin
               mag_q     <= dsr_abs;
               prem_q    <= dvd_abs[2*WIDTH-1:WIDTH];
               sh_q      <= dvd_abs[WIDTH-1:0];
               q_neg_q   <= hi_q[WIDTH-1] ^ dsr_q[WIDTH-1];
               r_neg_q   <= hi_q[WIDTH-1];
               ovf_pre_q <= dvd_abs[2*WIDTH-1:WIDTH] >= dsr_abs;
            end
            DIV: begin
               if (count_i != CNT_END) begin
                  prem_q <= fits ? diff : shifted[WIDTH-1:0];
                  sh_q   <= {sh_q[WIDTH-2:0], fits};
               end
            end
            FIX: begin
               if (is_div0) begin
                  quot_q <= '1;
                  rem_q  <= lo_q;
               end else if (is_ovf) begin
                  quot_q <= q_neg_q ? QMIN : QMAX;
                  rem_q  <= '0;
               end else begin
                  quot_q <= q_sgn;
                  rem_q  <= r_sgn;
               end
            end
            default: ;
         endcase
      end
   end

   assign quot_o = quot_q;
   assign rem_o  = rem_q;

`ifdef VEC_DIV_STATUS_EN
   logic div0_q, ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div0_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (state_i == FIX) begin
         div0_q <= is_div0;
         ovf_q  <= !is_div0 && is_ovf;
      end
   end

   assign div0_o = div0_q;
   assign ovf_o  = ovf_q;
`endif

endmodule

// File: rtl/vec_div_unit.sv
// Iterative signed vector divider: one FSM sequencing LANES independent divider lanes.
// Optional per-lane div0/ovf status outputs with VEC_DIV_STATUS_EN.
module vec_div_unit
   import vec_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIDTH-1:0] dividend_lo,
   input  logic [LANES*WIDTH-1:0] dividend_hi,
   input  logic [LANES*WIDTH-1:0] divisor,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WIDTH-1:0] quotient,
   output logic [LANES*WIDTH-1:0] remainder,
   output logic                   busy
`ifdef VEC_DIV_STATUS_EN
   ,
   output logic [LANES-1:0]       div0,
   output logic [LANES-1:0]       ovf
`endif
);

   state_t state_q;
   cnt_t   count_q;
   logic   in_ready_q, out_valid_q, busy_q;
   logic   load;

   assign load = (state_q == IDLE) && in_valid;

   // DIV spends one extra cycle observing count==CNT_END after the 32nd step;
   // this fixes accept-to-out_valid at 35 cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  state_q    <= PREP;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            PREP: begin
               count_q <= '0;
               state_q <= DIV;
            end
            DIV: begin
               if (count_q == CNT_END) state_q <= FIX;
               else                    count_q <= count_q + cnt_t'(1);
            end
            FIX: begin
               state_q     <= DONE;
               out_valid_q <= 1'b1;
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      vec_div_lane u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .state_i  (state_q),
         .count_i  (count_q),
         .load_i   (load),
         .dvd_lo_i (dividend_lo[WIDTH*i +: WIDTH]),
         .dvd_hi_i (dividend_hi[WIDTH*i +: WIDTH]),
         .dsr_i    (divisor[WIDTH*i +: WIDTH]),
         .quot_o   (quotient[WIDTH*i +: WIDTH]),
         .rem_o    (remainder[WIDTH*i +: WIDTH])
`ifdef VEC_DIV_STATUS_EN
         ,
         .div0_o   (div0[i]),
         .ovf_o    (ovf[i])
`endif
      );
   end

endmodule
